// File: rtl/modport_acc.sv
// modport_acc -- WIDTH-bit wrapping accumulator.
//
// Adds the unsigned addend `in` into an internal register on every rising
// clock edge where ceAcu is high. The sum wraps modulo 2^WIDTH and has no
// carry or saturation. The output is the register itself, so `in` and `ceAcu`
// have no combinational path to `out`.
//
// Ports
//   clk    : single clock; all state updates on the rising edge
//   rst    : asynchronous reset, active-low; clears the accumulator at once
//   in     : WIDTH-bit unsigned addend, sampled on the rising clk edge
//   ceAcu  : accumulate enable, active-high
//   out    : current accumulator value (registered)
module modport_acc #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             ceAcu,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] acc;

   // `in` is only read when ceAcu is high. An undriven addend therefore
   // cannot reach the register while the accumulator is holding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (ceAcu) begin
         acc <= acc + in;
      end
   end

   assign out = acc;

endmodule

// File: tb/tb_modport_acc.sv
// tb_modport_acc -- self-checking bench for modport_acc (WIDTH = 8).
// The reference model keeps the list of addends accepted since the last
// reset. The expected output is the sum of that list modulo 256. A compare
// process checks the DUT against the model on every falling clock edge.
// Directed literal checks from the stimulus pin both the model and the DUT.
module tb_modport_acc;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       ce;
   logic [7:0] dout;

   int vectors;
   int miscompares;
   bit started;

   // Addends accepted since the most recent reset.
   int unsigned accepted[$];

   modport_acc #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .in   (din),
      .ceAcu(ce),
      .out  (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (rst !== 1'b1)
            accepted.delete();
         else if (clk === 1'b1 && ce === 1'b1)
            accepted.push_back(int'(din));
      end
   end

   function automatic logic [7:0] model_value();
      int unsigned s;
      logic [31:0] w;
      s = 0;
      foreach (accepted[i]) s += accepted[i];
      w = s;
      return w[7:0];
   endfunction

   // Compare the DUT against the model on every falling clock edge.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (started) begin
            e = model_value();
            vectors++;
            if (dout !== e) begin
               miscompares++;
               $display("FAIL model_cmp t=%0t out=%h expected=%h", $time, dout, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] exp);
      vectors++;
      if (dout !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t out=%h expected=%h", name, $time, dout, exp);
      end
   endtask

   // Apply the inputs, then move to 1 time unit after the next rising edge.
   task automatic step(input logic [7:0] d, input logic c);
      din = d;
      ce  = c;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      started     = 1'b0;
      rst = 1'b1;
      ce  = 1'b0;
      din = 8'h00;

      // Assert reset with no clock edge in between.
      #2 rst = 1'b0;
      #1;
      started = 1'b1;
      check("reset_initial", 8'h00);
      step(8'h11, 1'b1); check("reset_hold_a", 8'h00);
      step(8'h11, 1'b1); check("reset_hold_b", 8'h00);

      // Release reset mid-cycle. The next edge accumulates.
      #2 rst = 1'b1;
      step(8'h05, 1'b1); check("acc_05", 8'h05);
      step(8'h0A, 1'b1); check("acc_0f", 8'h0F);
      step(8'h03, 1'b1); check("acc_12", 8'h12);

      // Hold with ceAcu low.
      for (int i = 0; i < 4; i++) begin
         step(8'h55, 1'b0); check("hold_12", 8'h12);
      end
      step(8'h55, 1'b1); check("acc_67", 8'h67);

      // Zero addend, and an undriven addend while holding.
      step(8'h00, 1'b1); check("zero_add", 8'h67);
      step(8'hxx, 1'b0); check("x_while_hold", 8'h67);

      // Wrap-around.
      step(8'h89, 1'b1); check("reach_f0", 8'hF0);
      step(8'h20, 1'b1); check("wrap_10", 8'h10);
      step(8'hEF, 1'b1); check("reach_ff", 8'hFF);
      step(8'h01, 1'b1); check("wrap_00", 8'h00);

      // Mid-cycle reset with a running sum of 0x37.
      step(8'h37, 1'b1); check("acc_37", 8'h37);
      #2 rst = 1'b0;
      #1 check("async_clear", 8'h00);
      step(8'h11, 1'b1); check("rst_stays_a", 8'h00);
      step(8'h11, 1'b1); check("rst_stays_b", 8'h00);
      din = 8'h22;
      #2 rst = 1'b1;
      step(8'h22, 1'b1); check("no_dead_cycle", 8'h22);

      // Random traffic with occasional reset pulses.
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            rst = 1'b0;
            step(8'($urandom), 1'($urandom_range(0, 1)));
            check("rand_reset", 8'h00);
            rst = 1'b1;
         end else begin
            step(8'($urandom), 1'($urandom_range(0, 1)));
         end
      end

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/modport_acc.md
MODPORT_ACC -- requirements
Module: modport_acc

Interface
REQ-001 Parameter: WIDTH, default 8, data width of in and out.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 Port: in  input  WIDTH  addend sampled on rising clk edge.
REQ-005 Port: ceAcu  input  1  accumulate enable, active-high.
REQ-006 Port: out  output  WIDTH  current accumulator value, driven directly from the accumulator register.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and rst.

Function
REQ-008 The block SHALL hold one WIDTH-bit accumulator register acc, with out = acc at all times and no combinational path from in or ceAcu to out.
REQ-009 On a rising clk edge with rst=1 and ceAcu=1, acc SHALL become (acc + in) mod 2^WIDTH.
REQ-010 On a rising clk edge with rst=1 and ceAcu=0, acc SHALL hold its value regardless of in.
REQ-011 Latency SHALL be exactly one clock: a value of in sampled at edge N is reflected in out after edge N.
REQ-012 Overflow SHALL wrap silently with no saturation and no carry output (8-bit: 0xFF + 0x01 -> 0x00; 0xF0 + 0x20 -> 0x10).
REQ-013 in=0 with ceAcu=1 SHALL leave acc unchanged.
REQ-014 Inputs SHALL be sampled only at the rising clk edge, so changes applied 1 time unit after the edge affect only the next edge.
REQ-015 X/Z on in while ceAcu=0 SHALL NOT corrupt acc.
REQ-016 Input in SHALL be treated as unsigned; addition is unsigned modulo 2^WIDTH.

Reset
REQ-017 When rst=0, acc and out SHALL become 0 immediately, without waiting for a clock edge.
REQ-018 While rst=0, acc SHALL remain 0 regardless of clk, ceAcu and in.
REQ-019 Reset asserted mid-accumulation SHALL discard the running sum; no partial update SHALL occur on the deasserting edge.
REQ-020 After rst rises to 1, the first rising clk edge SHALL accumulate normally if ceAcu=1 (no dead cycle).
REQ-021 Power-up value before the first reset is undefined; benches SHALL apply reset first.

Verification
REQ-022 Reset: rst=0 mid-cycle with acc=0x37 -> out=0x00 before the next clk edge; it stays 0x00 while rst=0 and ceAcu=1, in=0x11.
REQ-023 Accumulate: after reset, ceAcu=1 with in=0x05, 0x0A, 0x03 on three edges -> out=0x05, 0x0F, 0x12.
REQ-024 Hold: acc=0x12, ceAcu=0, in=0x55 for 4 edges -> out stays 0x12; ceAcu=1 on the next edge -> out=0x67.
REQ-025 Wrap: acc=0xF0, ceAcu=1, in=0x20 -> out=0x10; then in=0xEF -> out=0xFF; then in=0x01 -> out=0x00.
REQ-026 Random: 1000 cycles of random in/ceAcu with occasional rst=0 pulses; a scoreboard model (acc += in when ceAcu, zero on reset, mod 256) SHALL match out on every edge.
